// File: rtl/lsu_mem_ctrl_if.sv
// Handshake and memory-port bundle for the load/store control stage.
// slave: the control stage itself; master: the MEM-stage producer, the
// writeback consumer and the memory port seen together from the far side.
interface lsu_mem_ctrl_if #(
   parameter int TAG_W = 5
);
   // request from MEM stage
   logic             in_valid;
   logic             in_ready;
   logic             in_is_load;
   logic             in_is_store;
   logic [2:0]       in_op;
   logic [31:0]      in_addr;
   logic [31:0]      in_wdata;
   logic [TAG_W-1:0] in_tag;
   // response to writeback
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_rdata;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       out_err;
   // memory port
   logic             ld_wen;
   logic             st_wen;
   logic [31:0]      raddr;
   logic [31:0]      waddr;
   logic [7:0]       wmask;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             rdata_ok;
   logic             wdata_ok;

   modport slave (
      input  in_valid, in_is_load, in_is_store, in_op, in_addr, in_wdata, in_tag,
      output in_ready,
      output out_valid, out_rdata, out_tag, out_err,
      input  out_ready,
      output ld_wen, st_wen, raddr, waddr, wmask, wdata,
      input  rdata, rdata_ok, wdata_ok
   );

   modport master (
      output in_valid, in_is_load, in_is_store, in_op, in_addr, in_wdata, in_tag,
      input  in_ready,
      input  out_valid, out_rdata, out_tag, out_err,
      output out_ready,
      input  ld_wen, st_wen, raddr, waddr, wmask, wdata,
      output rdata, rdata_ok, wdata_ok
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of the memory port. One op in flight:
// classify, issue a single-cycle enable, wait for the matching ok (or time
// out), then hand an extended result to writeback.
module lsu_mem_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int TAG_W   = 5
) (
   input  logic            clock,
   input  logic            reset,
   lsu_mem_ctrl_if.slave   bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   typedef struct packed {
      logic             ld;
      logic             st;
      logic [2:0]       op;
      logic [31:0]      addr;
      logic [31:0]      wdata;
      logic [TAG_W-1:0] tag;
   } req_t;

   state_t         state, state_n;
   req_t           req;
   logic [CW-1:0]  cnt;
   logic [31:0]    res;
   logic [1:0]     err;

   logic [1:0]     off;
   logic [31:0]    word_addr;
   logic [31:0]    w;
   logic [31:0]    ld_data;
   logic           in_mem, ill, mis, ok_hit, tmo;

   assign off       = req.addr[1:0];
   assign word_addr = {req.addr[31:2], 2'b00};

   // Only the ok that matches the op in flight counts; the last allowed
   // WAIT cycle still accepts an ok before the timeout takes over.
   assign ok_hit = (req.ld && bus.rdata_ok) || (req.st && bus.wdata_ok);
   assign tmo    = (cnt == CW'(TIMEOUT - 1));

   // Classify the incoming op straight off the request bus.
   always_comb begin
      in_mem = bus.in_is_load || bus.in_is_store;
      ill    = (bus.in_is_load && bus.in_is_store) ||
               (in_mem && (bus.in_op == 3'b011 || bus.in_op == 3'b110 || bus.in_op == 3'b111)) ||
               (bus.in_is_store && (bus.in_op == 3'b100 || bus.in_op == 3'b101));
      mis    = in_mem &&
               (((bus.in_op[1:0] == 2'b01) && bus.in_addr[0]) ||
                ((bus.in_op == 3'b010) && (bus.in_addr[1:0] != 2'b00)));
   end

   // Pick the addressed lane out of the memory word and extend it.
   always_comb begin
      w = bus.rdata >> {off, 3'b000};
      case (req.op)
         3'b000:  ld_data = {{24{w[7]}}, w[7:0]};
         3'b100:  ld_data = {24'h0, w[7:0]};
         3'b001:  ld_data = {{16{w[15]}}, w[15:0]};
         3'b101:  ld_data = {16'h0, w[15:0]};
         default: ld_data = bus.rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next state plus handshake and memory-port outputs; memory side is
   // quiet outside REQ so the port sees exactly one enable per op.
   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.ld_wen    = 1'b0;
      bus.st_wen    = 1'b0;
      bus.raddr     = '0;
      bus.waddr     = '0;
      bus.wmask     = '0;
      bus.wdata     = '0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid)
               state_n = (ill || mis || !in_mem) ? RESP : REQ;
         end
         REQ: begin
            state_n = WAIT;
            if (req.ld) begin
               bus.ld_wen = 1'b1;
               bus.raddr  = word_addr;
            end
            if (req.st) begin
               bus.st_wen = 1'b1;
               bus.waddr  = word_addr;
               bus.wdata  = req.wdata << {off, 3'b000};
               case (req.op[1:0])
                  2'b00:   bus.wmask = {4'b0000, 4'b0001 << off};
                  2'b01:   bus.wmask = {4'b0000, 4'b0011 << off};
                  default: bus.wmask = 8'h0F;
               endcase
            end
         end
         WAIT: begin
            if (ok_hit || tmo) state_n = RESP;
         end
         RESP: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Request capture, wait counter and response payload.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req <= '0;
         cnt <= '0;
         res <= '0;
         err <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  req.ld    <= bus.in_is_load;
                  req.st    <= bus.in_is_store;
                  req.op    <= bus.in_op;
                  req.addr  <= bus.in_addr;
                  req.wdata <= bus.in_wdata;
                  req.tag   <= bus.in_tag;
                  res       <= '0;
                  cnt       <= '0;
                  err       <= ill ? 2'b11 : (mis ? 2'b01 : 2'b00);
               end
            end
            WAIT: begin
               cnt <= cnt + CW'(1);
               if (ok_hit) begin
                  res <= req.ld ? ld_data : 32'h0;
                  err <= 2'b00;
               end else if (tmo) begin
                  res <= '0;
                  err <= 2'b10;
               end
            end
            RESP: begin
               if (bus.out_ready) cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_rdata = res;
   assign bus.out_tag   = req.tag;
   assign bus.out_err   = err;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store control stage directly upstream of the DPI memory port block (dpi_ls).
- Accepts one memory op per handshake from the MEM pipeline stage.
- Checks alignment, generates the word address, byte mask and lane-shifted store data, and pulses ld_wen/st_wen.
- Waits for rdata_ok/wdata_ok, then extracts and sign/zero-extends load data and returns a result to writeback over a valid/ready handshake.

Parameters:
TIMEOUT, 16, max cycles in WAIT before aborting with timeout error (>=2)
TAG_W, 5, width of destination-register tag passed through

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_is_load  in  1  op is a load
in_is_store  in  1  op is a store
in_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  32  byte address
in_wdata  in  32  store data, right-justified
in_tag  in  TAG_W  destination tag
out_valid  out  1  response valid
out_ready  in  1  consumer accepts response
out_rdata  out  32  extended load data; 0 for stores and errors
out_tag  out  TAG_W  tag of the request
out_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal
ld_wen  out  1  load enable to memory port
st_wen  out  1  store enable to memory port
raddr  out  32  word-aligned load address
waddr  out  32  word-aligned store address
wmask  out  8  byte mask; bits [7:4] always 0
wdata  out  32  lane-shifted store data
rdata  in  32  memory word read data
rdata_ok  in  1  read data valid
wdata_ok  in  1  write completed

Behaviour:
- Reset (async, reset==0): state=IDLE; timeout counter=0.
  - Outputs during/after reset: in_ready=1, out_valid=0, ld_wen=st_wen=0, wmask=0, raddr=waddr=wdata=0, out_rdata=0, out_tag=0, out_err=0.
  - Reset mid-transaction abandons the op; no response is produced.
- States: IDLE, REQ, WAIT, RESP. in_ready=1 only in IDLE.
- IDLE: on in_valid&&in_ready, register op, addr, wdata, tag and off=addr[1:0]. Then classify:
  - Illegal (go RESP, err=11, no memory access): in_is_load&&in_is_store, or a load/store with in_op in {011,110,111}, or a store with in_op in {100,101}.
  - Misaligned (go RESP, err=01, no memory access): H/HU with off[0]=1; W with off!=0.
  - Neither load nor store: go RESP, err=00, rdata=0.
  - Otherwise: go REQ.
- REQ (exactly one cycle): drive ld_wen=1 (load) or st_wen=1 (store); go WAIT.
  - raddr/waddr = {addr[31:2],2'b00}.
  - Store mask: B → 4'b0001<<off; H → 4'b0011<<off; W → 4'b1111.
  - wdata = in_wdata << (8*off).
  - All memory-side outputs are 0 in every state except REQ.
- WAIT: counter increments each cycle.
  - Load with rdata_ok=1: w = rdata >> (8*off). B → sext(w[7:0]); BU → zext(w[7:0]); H → sext(w[15:0]); HU → zext(w[15:0]); W → rdata. Set err=00; go RESP.
  - Store with wdata_ok=1: rdata=0, err=00; go RESP.
  - Counter reaches TIMEOUT with no ok: err=10, rdata=0; go RESP.
  - An ok arriving in the same cycle as the timeout wins.
  - The wrong-kind ok (wdata_ok during a load, or vice versa) is ignored.
- RESP: out_valid=1; out_rdata/out_tag/out_err held stable until out_ready. On out_ready go IDLE and clear the counter.
- rdata_ok/wdata_ok seen in IDLE, REQ or RESP are ignored.
- Latency with a one-cycle-response memory: accept edge → REQ → WAIT (ok) → out_valid on the 3rd cycle after accept. Peak throughput is 1 op per 4 cycles.

Test Plan:
- LB addr=0x80000003, rdata=0x80FF1234 → ld_wen 1 cycle, raddr=0x80000000; out_rdata=0xFFFFFF80, err=00, out_valid 3 cycles after accept.
- LHU addr=0x80000002, rdata=0xBEEF0000 → out_rdata=0x0000BEEF. LW same word → 0xBEEF0000.
- SB addr=0x80000001, wdata=0x000000AB → st_wen 1 cycle, waddr=0x80000000, wmask=0x02, wdata=0x0000AB00. SH off=2 wdata=0x1234 → wmask=0x0C, wdata=0x12340000.
- SW addr=0x80000002 → no st_wen, err=01 next cycle. LH addr=...1 → err=01. in_is_load&&in_is_store → err=11.
- Memory never asserts ok, TIMEOUT=16 → err=10, out_rdata=0; wdata_ok pulsed during a load is ignored.
- Hold out_ready=0 for 5 cycles in RESP → outputs stable, in_ready=0. Assert reset while in WAIT → immediately IDLE, out_valid=0, ld_wen=0; a late rdata_ok produces no response.
